// File: rtl/mux_arb_n_if.sv
// Handshake bundle for mux_arb_n: N request channels in, one registered word out.
// The arbiter takes the slave view; producers and the consumer take the master view.
interface mux_arb_n_if #(
    parameter int N     = 4,
    parameter int WIDTH = 32,
    parameter int SELW  = $clog2(N)
) ();
    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_ready;
    logic [SELW-1:0]    ext_sel;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_sel;
    logic               out_ready;

    modport master (
        output in_valid, in_data, ext_sel, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    modport slave (
        input  in_valid, in_data, ext_sel, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/mux_arb_n.sv
// N-channel registered arbitrating multiplexer: round-robin, fixed-priority or
// externally selected grant, one-cycle latency, full throughput under drain.
module mux_arb_n #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SELW  = $clog2(N),
    parameter int MODE  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    mux_arb_n_if.slave bus
);
    logic             load_s;
    logic             found_s;
    logic             found_hi_s;
    logic [N-1:0]     elig_s;
    logic [N-1:0]     ready_s;
    logic [SELW-1:0]  base_s;
    logic [SELW-1:0]  grant_hi_s;
    logic [SELW-1:0]  grant_lo_s;
    logic [SELW-1:0]  grant_s;
    logic [WIDTH-1:0] data_s;

    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic [SELW-1:0]  out_sel_r;
    logic [SELW-1:0]  ptr_r;

    // Eligibility: every valid channel, or only the externally selected one
    always_comb begin
        elig_s = '0;
        for (int k = 0; k < N; k++) begin
            if (MODE == 2) begin
                elig_s[k] = bus.in_valid[k] && (bus.ext_sel == SELW'(k));
            end else begin
                elig_s[k] = bus.in_valid[k];
            end
        end
    end

    // Grant search: lowest eligible index at or above base, else lowest overall.
    // With base forced to 0 outside round-robin this degenerates to fixed priority.
    always_comb begin
        base_s     = (MODE == 0) ? ptr_r : '0;
        found_hi_s = 1'b0;
        grant_hi_s = '0;
        grant_lo_s = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (elig_s[k]) begin
                grant_lo_s = SELW'(k);
                if (SELW'(k) >= base_s) begin
                    grant_hi_s = SELW'(k);
                    found_hi_s = 1'b1;
                end else begin
                    found_hi_s = found_hi_s;
                end
            end else begin
                found_hi_s = found_hi_s;
            end
        end
        found_s = |elig_s;
        grant_s = found_hi_s ? grant_hi_s : grant_lo_s;
    end

    // Accept strobes and the data word of the granted channel
    always_comb begin
        load_s  = !out_valid_r || bus.out_ready;
        ready_s = '0;
        data_s  = '0;
        for (int k = 0; k < N; k++) begin
            if (grant_s == SELW'(k)) begin
                ready_s[k] = rst_n && load_s && found_s;
                data_s     = bus.in_data[k*WIDTH +: WIDTH];
            end else begin
                ready_s[k] = 1'b0;
            end
        end
    end

    // Output register and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_sel_r   <= '0;
            ptr_r       <= '0;
        end else if (load_s) begin
            if (found_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= data_s;
                out_sel_r   <= grant_s;
                if (MODE == 0) begin
                    // explicit wrap so non-power-of-two N never reaches index N
                    ptr_r <= (grant_s == SELW'(N - 1)) ? '0 : grant_s + SELW'(1);
                end else begin
                    ptr_r <= '0;
                end
            end else begin
                out_valid_r <= 1'b0;
            end
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign bus.in_ready  = ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_sel   = out_sel_r;
endmodule
